// File: rtl/trap_ctrl_pkg.sv
// Shared trap cause codes, interrupt line indices and sequencer state encodings.
package trap_ctrl_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] CAUSE_ILL     = 32'h0000_0002;
   localparam logic [XLEN-1:0] CAUSE_BRK     = 32'h0000_0003;
   localparam logic [XLEN-1:0] CAUSE_LD_MIS  = 32'h0000_0004;
   localparam logic [XLEN-1:0] CAUSE_ST_MIS  = 32'h0000_0006;
   localparam logic [XLEN-1:0] CAUSE_ECALL_M = 32'h0000_000B;
   localparam logic [XLEN-1:0] CAUSE_MSI     = 32'h8000_0003;
   localparam logic [XLEN-1:0] CAUSE_MTI     = 32'h8000_0007;
   localparam logic [XLEN-1:0] CAUSE_MEI     = 32'h8000_000B;

   // Bit positions inside the {ext,timer,soft} enable mask.
   localparam int unsigned IRQ_EXT = 2;
   localparam int unsigned IRQ_TMR = 1;
   localparam int unsigned IRQ_SW  = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTER = 2'd1,
      ST_EXIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// N-stage level synchroniser for one asynchronous interrupt line.
module trap_ctrl_irq_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_irq,
   output logic o_irq
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[STAGES-2:0], i_irq};
   end

   assign o_irq = sync_q[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: arbitrates exceptions, interrupts and mret, then
// pulses the CSR enter/exit handshake and stalls while the PC is redirected.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_instr_valid,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [XLEN-1:0]  i_instr,
   input  logic             i_ill_instr,
   input  logic             i_ecall,
   input  logic             i_ebreak,
   input  logic             i_ld_misalign,
   input  logic             i_st_misalign,
   input  logic [XLEN-1:0]  i_mem_addr,
   input  logic             i_mret,
   input  logic             i_irq_ext,
   input  logic             i_irq_timer,
   input  logic             i_irq_soft,
   input  logic             i_mie_global,
   input  logic [2:0]       i_mie_mask,
   output logic             o_interrupt_enter,
   output logic             o_interrupt_exit,
   output logic [XLEN-1:0]  o_int_cause,
   output logic [XLEN-1:0]  o_int_pc,
   output logic [XLEN-1:0]  o_int_mtval,
   output logic             o_flush,
   output logic             o_stall
);

   localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              enter_q, exit_q, flush_q, stall_q;
   logic [XLEN-1:0]   cause_q, pc_q, mtval_q;

   logic [2:0]        irq_sync;
   logic [2:0]        irq_pend;
   logic              req_enter, req_exit;
   logic [XLEN-1:0]   req_cause, req_mtval;

   trap_ctrl_irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync_ext (
      .clk(clk), .rst(rst), .i_irq(i_irq_ext),   .o_irq(irq_sync[IRQ_EXT]));
   trap_ctrl_irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync_tmr (
      .clk(clk), .rst(rst), .i_irq(i_irq_timer), .o_irq(irq_sync[IRQ_TMR]));
   trap_ctrl_irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync_sw (
      .clk(clk), .rst(rst), .i_irq(i_irq_soft),  .o_irq(irq_sync[IRQ_SW]));

   assign irq_pend = irq_sync & i_mie_mask & {3{i_mie_global}};

   // Request arbitration; an interrupt beside mret takes mepc=i_pc so mret re-executes.
   always_comb begin
      req_enter = 1'b0;
      req_exit  = 1'b0;
      req_cause = '0;
      req_mtval = '0;
      if (i_instr_valid) begin
         if (i_ill_instr) begin
            req_enter = 1'b1; req_cause = CAUSE_ILL;     req_mtval = i_instr;
         end else if (i_ebreak) begin
            req_enter = 1'b1; req_cause = CAUSE_BRK;     req_mtval = i_pc;
         end else if (i_ecall) begin
            req_enter = 1'b1; req_cause = CAUSE_ECALL_M;
         end else if (i_ld_misalign) begin
            req_enter = 1'b1; req_cause = CAUSE_LD_MIS;  req_mtval = i_mem_addr;
         end else if (i_st_misalign) begin
            req_enter = 1'b1; req_cause = CAUSE_ST_MIS;  req_mtval = i_mem_addr;
         end else if (irq_pend[IRQ_EXT]) begin
            req_enter = 1'b1; req_cause = CAUSE_MEI;
         end else if (irq_pend[IRQ_SW]) begin
            req_enter = 1'b1; req_cause = CAUSE_MSI;
         end else if (irq_pend[IRQ_TMR]) begin
            req_enter = 1'b1; req_cause = CAUSE_MTI;
         end else if (i_mret) begin
            req_exit  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         enter_q <= 1'b0;
         exit_q  <= 1'b0;
         flush_q <= 1'b0;
         stall_q <= 1'b0;
         cause_q <= '0;
         pc_q    <= '0;
         mtval_q <= '0;
      end else begin
         enter_q <= 1'b0;
         exit_q  <= 1'b0;
         flush_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_enter) begin
                  state_q <= ST_ENTER;
                  enter_q <= 1'b1;
                  flush_q <= 1'b1;
                  stall_q <= 1'b1;
                  cause_q <= req_cause;
                  pc_q    <= i_pc;
                  mtval_q <= req_mtval;
               end else if (req_exit) begin
                  state_q <= ST_EXIT;
                  exit_q  <= 1'b1;
                  flush_q <= 1'b1;
                  stall_q <= 1'b1;
               end
            end
            ST_ENTER, ST_EXIT: begin
               state_q <= ST_HOLD;
               cnt_q   <= CNT_W'(HOLD_CYCLES);
               stall_q <= 1'b1;
            end
            ST_HOLD: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  stall_q <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               stall_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_interrupt_enter = enter_q;
   assign o_interrupt_exit  = exit_q;
   assign o_int_cause       = cause_q;
   assign o_int_pc          = pc_q;
   assign o_int_mtval       = mtval_q;
   assign o_flush           = flush_q;
   assign o_stall           = stall_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: vector table for single-request arbitration plus
// hand sequences for interrupt sync latency, mret during hold and reset in hold.
module tb_trap_ctrl;
   import trap_ctrl_pkg::*;

   localparam int unsigned HOLD = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, ill, ecall, ebreak, ld_mis, st_mis, mret;
   logic [31:0] pc, instr, mem_addr;
   logic        irq_ext, irq_timer, irq_soft, mie_global;
   logic [2:0]  mie_mask;
   logic        enter, exit_p, flush, stall;
   logic [31:0] cause, int_pc, mtval;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   trap_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(HOLD)) u_dut (
      .clk(clk), .rst(rst),
      .i_instr_valid(valid), .i_pc(pc), .i_instr(instr),
      .i_ill_instr(ill), .i_ecall(ecall), .i_ebreak(ebreak),
      .i_ld_misalign(ld_mis), .i_st_misalign(st_mis), .i_mem_addr(mem_addr),
      .i_mret(mret), .i_irq_ext(irq_ext), .i_irq_timer(irq_timer), .i_irq_soft(irq_soft),
      .i_mie_global(mie_global), .i_mie_mask(mie_mask),
      .o_interrupt_enter(enter), .o_interrupt_exit(exit_p),
      .o_int_cause(cause), .o_int_pc(int_pc), .o_int_mtval(mtval),
      .o_flush(flush), .o_stall(stall)
   );

   typedef struct {
      logic        v, ill, brk, ecl, ld, st, mr;
      logic [31:0] pc, instr, addr;
      logic        e_enter, e_exit;
      logic [31:0] e_cause, e_pc, e_mtval;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_req();
      valid = 0; ill = 0; ecall = 0; ebreak = 0; ld_mis = 0; st_mis = 0; mret = 0;
   endtask

   // After a pulse cycle: HOLD stalled cycles with no pulse, then stall released.
   task automatic check_hold(input string tag);
      for (int k = 0; k < int'(HOLD); k++) begin
         tick();
         chk({tag, " hold stall"}, 32'(stall), 32'd1);
         chk({tag, " hold enter"}, 32'(enter), 32'd0);
         chk({tag, " hold exit"},  32'(exit_p), 32'd0);
      end
      tick();
      chk({tag, " stall release"}, 32'(stall), 32'd0);
      chk({tag, " release exit"},  32'(exit_p), 32'd0);
   endtask

   task automatic wait_enter(input string tag, input int max_cyc);
      int n = 0;
      while (enter !== 1'b1 && n < max_cyc) begin
         tick();
         n++;
      end
      chk({tag, " enter seen"}, 32'(enter), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      //             v  il br ec ld st mr  pc            instr         addr          en ex cause         pc            mtval
      vecs[0] = '{1, 1, 0, 0, 0, 0, 0, 32'h100, 32'hFFFF_FFFF, 32'h0,    1, 0, 32'h2,         32'h100, 32'hFFFF_FFFF};
      vecs[1] = '{1, 1, 1, 0, 0, 0, 1, 32'h104, 32'h1234_5678, 32'h0,    1, 0, 32'h2,         32'h104, 32'h1234_5678};
      vecs[2] = '{1, 0, 1, 1, 0, 0, 0, 32'h108, 32'h0,         32'h0,    1, 0, 32'h3,         32'h108, 32'h108};
      vecs[3] = '{1, 0, 0, 1, 1, 0, 1, 32'h10C, 32'h0,         32'h2001, 1, 0, 32'hB,         32'h10C, 32'h0};
      vecs[4] = '{1, 0, 0, 0, 1, 1, 0, 32'h110, 32'h0,         32'h3003, 1, 0, 32'h4,         32'h110, 32'h3003};
      vecs[5] = '{1, 0, 0, 0, 0, 1, 0, 32'h114, 32'h0,         32'h4002, 1, 0, 32'h6,         32'h114, 32'h4002};
      vecs[6] = '{1, 0, 0, 0, 0, 0, 1, 32'h118, 32'h0,         32'h0,    0, 1, 32'h6,         32'h114, 32'h4002};
      vecs[7] = '{0, 1, 0, 0, 0, 0, 0, 32'h11C, 32'hDEAD_BEEF, 32'h0,    0, 0, 32'h6,         32'h114, 32'h4002};
      vecs[8] = '{1, 0, 0, 0, 0, 0, 0, 32'h120, 32'h0,         32'h0,    0, 0, 32'h6,         32'h114, 32'h4002};

      rst = 1; clr_req(); pc = 0; instr = 0; mem_addr = 0;
      irq_ext = 0; irq_timer = 0; irq_soft = 0; mie_global = 1; mie_mask = 3'b000;
      tick(); tick();
      chk("reset enter", 32'(enter), 32'd0);
      chk("reset exit",  32'(exit_p), 32'd0);
      chk("reset stall", 32'(stall), 32'd0);
      chk("reset flush", 32'(flush), 32'd0);
      chk("reset cause", cause, 32'd0);
      rst = 0;
      tick();

      for (int i = 0; i < 9; i++) begin
         valid = vecs[i].v; ill = vecs[i].ill; ebreak = vecs[i].brk; ecall = vecs[i].ecl;
         ld_mis = vecs[i].ld; st_mis = vecs[i].st; mret = vecs[i].mr;
         pc = vecs[i].pc; instr = vecs[i].instr; mem_addr = vecs[i].addr;
         tick();
         chk($sformatf("vec%0d enter", i), 32'(enter),  32'(vecs[i].e_enter));
         chk($sformatf("vec%0d exit", i),  32'(exit_p), 32'(vecs[i].e_exit));
         chk($sformatf("vec%0d cause", i), cause, vecs[i].e_cause);
         chk($sformatf("vec%0d pc", i),    int_pc, vecs[i].e_pc);
         chk($sformatf("vec%0d mtval", i), mtval, vecs[i].e_mtval);
         chk($sformatf("vec%0d flush", i), 32'(flush), 32'(vecs[i].e_enter | vecs[i].e_exit));
         chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].e_enter | vecs[i].e_exit));
         clr_req();
         if (vecs[i].e_enter || vecs[i].e_exit) check_hold($sformatf("vec%0d", i));
      end

      // External interrupt: enters on the third edge after the line rises.
      irq_ext = 1; mie_mask = 3'b100; mie_global = 1; valid = 1; pc = 32'h200;
      tick(); chk("ext lat c1", 32'(enter), 32'd0);
      tick(); chk("ext lat c2", 32'(enter), 32'd0);
      tick(); chk("ext lat c3", 32'(enter), 32'd1);
      chk("ext cause", cause, 32'h8000_000B);
      chk("ext pc",    int_pc, 32'h200);
      chk("ext mtval", mtval, 32'h0);
      irq_ext = 0;
      check_hold("ext");

      // Global enable off: no entry at all.
      begin
         logic seen = 1'b0;
         mie_global = 0; mie_mask = 3'b111; irq_ext = 1;
         repeat (20) begin
            tick();
            if (enter) seen = 1'b1;
         end
         chk("mie_global off no entry", 32'(seen), 32'd0);
         irq_ext = 0;
         repeat (3) tick();
         mie_global = 1;
      end

      // ext and timer together, then timer alone.
      mie_mask = 3'b110; irq_ext = 1; irq_timer = 1; valid = 1; pc = 32'h204;
      wait_enter("ext+tmr", 10);
      chk("ext+tmr cause", cause, 32'h8000_000B);
      irq_ext = 0;
      tick(); tick(); tick();
      wait_enter("tmr", 10);
      chk("tmr cause", cause, 32'h8000_0007);
      chk("tmr mtval", mtval, 32'h0);
      chk("tmr pc",    int_pc, 32'h204);
      irq_timer = 0; mie_mask = 3'b000; clr_req();
      check_hold("tmr");

      // Soft irq is masked while no valid instruction; ecall then beats it.
      irq_soft = 1; mie_mask = 3'b001; valid = 0;
      repeat (3) tick();
      chk("soft masked by invalid", 32'(enter), 32'd0);
      valid = 1; ecall = 1; pc = 32'h300;
      tick();
      chk("ecall+soft enter", 32'(enter), 32'd1);
      chk("ecall+soft cause", cause, 32'hB);
      chk("ecall+soft pc",    int_pc, 32'h300);
      chk("ecall+soft mtval", mtval, 32'h0);
      irq_soft = 0; mie_mask = 3'b000; clr_req();
      check_hold("ecall");

      // mret held through HOLD must pulse exit exactly once.
      valid = 1; mret = 1; pc = 32'h400;
      tick();
      chk("mret exit",  32'(exit_p), 32'd1);
      chk("mret enter", 32'(enter), 32'd0);
      chk("mret flush", 32'(flush), 32'd1);
      chk("mret stall", 32'(stall), 32'd1);
      chk("mret cause hold", cause, 32'hB);
      chk("mret pc hold",    int_pc, 32'h300);
      check_hold("mret");
      clr_req();
      tick();

      // Reset in HOLD after ebreak, then a fresh store misalign.
      valid = 1; ebreak = 1; pc = 32'h500;
      tick();
      chk("ebreak cause", cause, 32'h3);
      chk("ebreak mtval", mtval, 32'h500);
      clr_req();
      tick();
      chk("ebreak in hold", 32'(stall), 32'd1);
      rst = 1;
      tick();
      chk("rst hold enter", 32'(enter), 32'd0);
      chk("rst hold exit",  32'(exit_p), 32'd0);
      chk("rst hold stall", 32'(stall), 32'd0);
      chk("rst hold flush", 32'(flush), 32'd0);
      chk("rst hold cause", cause, 32'd0);
      chk("rst hold pc",    int_pc, 32'd0);
      chk("rst hold mtval", mtval, 32'd0);
      rst = 0;
      tick();
      chk("post rst idle", 32'(stall), 32'd0);
      valid = 1; st_mis = 1; mem_addr = 32'h1002; pc = 32'h504;
      tick();
      chk("st_mis enter", 32'(enter), 32'd1);
      chk("st_mis cause", cause, 32'h6);
      chk("st_mis mtval", mtval, 32'h1002);
      chk("st_mis pc",    int_pc, 32'h504);
      clr_req();
      check_hold("st_mis");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
